mod_mul: RTL and testbench

//   Sequential modular multiplier over the Ed448 field: res = a*b mod PRIME.
//   Bit-serial interleaved (MSB-first double-and-add), one bit of b per clock.

---
 rtl/mod_mul.sv | 113 +++++++++++
 tb/tb_mod_mul.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul.sv
// Bit-serial Ed448 field multiplier: res = a*b mod PRIME, MSB-first double-and-add,
// one multiplier bit per clock, start/done handshake shared with the inverter.
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  localparam logic [DATA_WIDTH-1:0] PRIME = {{223{1'b1}}, 1'b0, {224{1'b1}}};
endpackage

module mod_mul
  import parameters_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  done,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH:0] PRIME_X = {1'b0, PRIME};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;

  logic [DATA_WIDTH-1:0] w_a_red;
  logic [DATA_WIDTH:0]   w_dbl;
  logic [DATA_WIDTH:0]   w_dbl_red;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_acc_next;

  // Both partial sums stay below 2*PRIME, so one extra bit and one
  // conditional subtract per step keep acc fully reduced.
  assign w_a_red    = (a >= PRIME) ? a - PRIME : a;
  assign w_dbl      = {r_acc, 1'b0};
  assign w_dbl_red  = (w_dbl >= PRIME_X) ? w_dbl - PRIME_X : w_dbl;
  assign w_sum      = r_b[r_cnt] ? w_dbl_red + {1'b0, r_a} : w_dbl_red;
  assign w_acc_next = (w_sum >= PRIME_X) ? DATA_WIDTH'(w_sum - PRIME_X)
                                         : DATA_WIDTH'(w_sum);

  // NOTE: synchronous reset -- rst_n is only seen at a rising edge, and it
  // abandons any operation in flight without producing done.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // the cycle in which done is high still refuses a new start
        if (start && !done) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      r_acc <= '0;
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= w_a_red;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= CNT_W'(DATA_WIDTH - 1);
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_DONE: begin
          res  <= r_acc;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul.sv
// Self-checking bench for mod_mul: directed corner cases, handshake/reset behaviour
// and random operands against a wide-arithmetic reference, via a result scoreboard.
module tb_mod_mul;

  localparam int DW  = 448;
  localparam int LAT = 449;
  localparam logic [DW-1:0] PRIME_TB = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] tb_a;
  logic [DW-1:0] tb_b;
  logic [DW-1:0] res;
  logic          done;
  logic          busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mod_mul dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (tb_a),
    .b    (tb_b),
    .res  (res),
    .done (done),
    .busy (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [2*DW-1:0] p;
    p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    p = p % {{DW{1'b0}}, PRIME_TB};
    return DW'(p);
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    if (v >= PRIME_TB) v = v - PRIME_TB;
    return v;
  endfunction

  // Called #1 after an edge: drives start, the next edge accepts.
  task automatic start_op(input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [DW-1:0] expv, input bit push);
    tb_a  = x;
    tb_b  = y;
    start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    tb_a  = rnd();
    tb_b  = rnd();
    check_i("busy_after_accept", int'(busy), 1);
  endtask

  // Waits (bounded) for done, then checks latency, busy and the scoreboard head.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    int busy_gaps;
    lat       = 0;
    busy_gaps = 0;
    for (int k = 1; k <= LAT + 50; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_gaps++;
    end
    check_i({tag, "_latency"}, lat, exp_lat);
    check_i({tag, "_busy_during_run"}, busy_gaps, 0);
    check_i({tag, "_busy_at_done"}, int'(busy), 0);
    n_tests++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected pending result", tag);
    end
    if (exp_q.size() != 0) check({tag, "_res"}, res, exp_q.pop_front());
  endtask

  task automatic end_op();
    @(posedge clk);
    #1;
    check_i("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            n_done;

    rst_n = 1'b0;
    start = 1'b0;
    tb_a  = '0;
    tb_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_res", res, DW'(0));
    check_i("reset_done", int'(done), 0);
    check_i("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1) small operands, full latency and one-cycle done
    start_op(DW'(5), DW'(7), DW'(35), 1'b1);
    wait_done("small", LAT);
    end_op();

    // 2) wrap reduction: 2 * 2^447 = 2^448 == 2^224 + 1
    start_op(DW'(2), DW'(1) << 447, (DW'(1) << 224) + DW'(1), 1'b1);
    wait_done("wrap", LAT);
    end_op();
    start_op(PRIME_TB - DW'(1), PRIME_TB - DW'(1), DW'(1), 1'b1);
    wait_done("pm1_sq", LAT);
    end_op();

    // 3) zero and identity
    start_op(DW'(0), PRIME_TB - DW'(1), DW'(0), 1'b1);
    wait_done("zero", LAT);
    end_op();
    x = rnd();
    start_op(DW'(1), x, x, 1'b1);
    wait_done("identity", LAT);
    end_op();

    // 4) start mid-run and in the done cycle is ignored; earliest restart accepted
    start_op(DW'(5), DW'(7), DW'(35), 1'b1);
    repeat (100) @(posedge clk);
    #1;
    tb_a  = DW'(9);
    tb_b  = DW'(9);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_i("busy_mid_run", int'(busy), 1);
    wait_done("ignore_mid", LAT - 101);
    tb_a  = DW'(9);
    tb_b  = DW'(9);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_i("done_cycle_width", int'(done), 0);
    check_i("start_in_done_ignored", int'(busy), 0);
    start_op(DW'(3), DW'(17), DW'(51), 1'b1);
    wait_done("back_to_back", LAT);
    end_op();

    // 5) reset mid-run abandons the operation
    start_op(DW'(5), DW'(7), DW'(35), 1'b0);
    repeat (199) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_res", res, DW'(0));
    check_i("midreset_busy", int'(busy), 0);
    check_i("midreset_done", int'(done), 0);
    n_done = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_i("midreset_no_done", n_done, 0);
    start_op(DW'(5), DW'(7), DW'(35), 1'b1);
    wait_done("after_reset", LAT);
    end_op();

    // 6) random operands against the wide reference
    for (int i = 0; i < 120; i++) begin
      x = rnd();
      y = rnd();
      start_op(x, y, ref_mul(x, y), 1'b1);
      wait_done("rand", LAT);
      end_op();
    end

    check_i("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
